button_count_pulse_gen: RTL

- Upstream stage of the 3-bit up counter. Takes a raw, bouncing push-button input and produces a clean single-cycle count pulse for the counter's clock-enable input.
- Internal chain: 2-flop synchroniser, debounce FSM, rising-edge pulse generator.
- One pulse out per debounced press. Optional auto-repeat while the button is held.

---
 rtl/btn_pkg.sv | 13 +
 rtl/sync_2ff.sv | 12 +
 rtl/button_count_pulse_gen.sv | 86 ++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: debounce FSM state encoding and default timing constants for the button pulse generator
package btn_pkg;
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;
  localparam int CNT_W_DEF         = 8;
  localparam int STABLE_CYCLES_DEF = 16;
  localparam int REPEAT_DELAY_DEF  = 200;
  localparam int REPEAT_RATE_DEF   = 50;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous single-bit inputs, async active-low reset to 0
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {q, s1_q} <= 2'b00;
    else      {q, s1_q} <= {s1_q, d};
endmodule

// File: rtl/button_count_pulse_gen.sv
// button_count_pulse_gen: synchronise + debounce a push-button and emit one count pulse per press.
// Define AUTO_REPEAT_EN to add hold-to-repeat pulses (REPEAT_DELAY, then every REPEAT_RATE cycles).
module button_count_pulse_gen
  import btn_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE   = REPEAT_RATE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse_out,
  output logic btn_level
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 2**CNT_W || REPEAT_DELAY > 2**CNT_W ||
      REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_cfg
    $error("button_count_pulse_gen: invalid timing parameters");
  end
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync, done, press_d, pulse_d, pulse_q, level_d, level_q;
  sync_2ff u_sync (.clk(clk), .rst(rst), .d(btn_in), .q(sync));
  assign done = cnt_q == LAST;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      IDLE: if (sync) begin
        state_d = WAIT_PRESS;
        cnt_d   = '0;
      end
      WAIT_PRESS:
        if (!sync) state_d = IDLE;
        else if (done) begin
          state_d = PRESSED;
          press_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      PRESSED: if (!sync) begin
        state_d = WAIT_RELEASE;
        cnt_d   = '0;
      end
      WAIT_RELEASE:
        if (sync) state_d = PRESSED;
        else if (done) state_d = IDLE;
        else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
    level_d = state_d inside {PRESSED, WAIT_RELEASE};
  end
`ifdef AUTO_REPEAT_EN
  // rcnt tracks hold time; after the first repeat it reloads so the next fires REPEAT_RATE later
  localparam logic [CNT_W-1:0] RLAST   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RRELOAD = CNT_W'(REPEAT_DELAY - REPEAT_RATE);
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             stay, rep;
  always_comb begin
    stay   = state_q == PRESSED && sync;
    rep    = stay && rcnt_q == RLAST;
    rcnt_d = !stay ? '0 : rep ? RRELOAD : rcnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) rcnt_q <= '0;
    else      rcnt_q <= rcnt_d;
  assign pulse_d = press_d | rep;
`else
  assign pulse_d = press_d;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  assign pulse_out = pulse_q;
  assign btn_level = level_q;
endmodule
